// File: rtl/mvm_tile_sequencer_if.sv
// Config bus, run status and PE-array/shared-memory ports of mvm_tile_sequencer.
// master = config (SPI) side, slave = the sequencer.
interface mvm_tile_sequencer_if #(
  parameter int ADDR_SIZE = 10,
  parameter int PE_NUMBER = 64
);
  logic                                cfg_we;
  logic [1:0]                          cfg_addr;
  logic [15:0]                         cfg_wdata;
  logic                                cfg_ready;
  logic                                busy;
  logic                                done;
  logic                                array_clr;
  logic                                array_read;
  logic [PE_NUMBER-1:0][ADDR_SIZE-1:0] pe_t_o_addr;
  logic [ADDR_SIZE-1:0]                l_d_o_addr;
  logic [ADDR_SIZE-1:0]                w_addr;
  logic                                w_en;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    input  cfg_ready, busy, done, array_clr, array_read,
    input  pe_t_o_addr, l_d_o_addr, w_addr, w_en
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    output cfg_ready, busy, done, array_clr, array_read,
    output pe_t_o_addr, l_d_o_addr, w_addr, w_en
  );
endinterface

// File: rtl/mvm_tile_sequencer.sv
// Tiled matrix-vector multiply sequencer: walks vector tiles of PE_NUMBER columns, then writes M results.
// Optional feature macro MVM_SEQ_AUTOINC_EN: advance RES_BASE by M after every successful run.
module mvm_tile_sequencer #(
  parameter int                   ADDR_SIZE       = 10,
  parameter int                   PE_NUMBER       = 64,
  parameter int                   DIM_W           = 8,
  parameter logic [ADDR_SIZE-1:0] VEC_BASE        = ADDR_SIZE'(32'h0000_000f),
  parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = '1
) (
  input logic                 clk,
  input logic                 reset,
  mvm_tile_sequencer_if.slave bus
);
  localparam int CW     = DIM_W + 1;
  localparam int PE_SAT = (PE_NUMBER < (1 << DIM_W)) ? PE_NUMBER : (1 << DIM_W);
  localparam logic [CW-1:0] PE_STEP = CW'(PE_SAT);
  localparam logic [CW-1:0] ONE_CW  = CW'(32'd1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                              state_r, state_s;
  logic [DIM_W-1:0]                    n_r, n_s, m_r, m_s;
  logic [ADDR_SIZE-1:0]                res_base_r, res_base_s;
  logic [CW-1:0]                       col_r, col_s, c_r, c_s;
  logic [ADDR_SIZE-1:0]                row_r, row_s;
  logic [CW-1:0]                       rem_s, nt_s, m_w_s, fetch_len_s, drain_len_s;
  logic                                start_s;
  logic                                cfg_unused_s;

  logic                                cfg_ready_r, busy_r, done_r, clr_r, read_r, w_en_r;
  logic [ADDR_SIZE-1:0]                l_d_r, w_addr_r;
  logic [PE_NUMBER-1:0][ADDR_SIZE-1:0] pe_r;
  logic                                busy_s, done_s, clr_s, read_s;
  logic [ADDR_SIZE-1:0]                l_d_s, w_addr_s, pe_base_s;
  logic [PE_NUMBER-1:0][ADDR_SIZE-1:0] pe_s;

  assign cfg_unused_s = ^bus.cfg_wdata;

  // Geometry of the current tile: active columns n_t and the FETCH/DRAIN lengths.
  always_comb begin
    rem_s       = CW'(n_r) - col_r;
    m_w_s       = CW'(m_r);
    nt_s        = (rem_s < PE_STEP) ? rem_s : PE_STEP;
    fetch_len_s = (nt_s > m_w_s) ? nt_s : m_w_s;
    drain_len_s = nt_s + m_w_s - ONE_CW;
  end

  // Next-state, config register and loop-counter logic.
  always_comb begin
    state_s    = state_r;
    n_s        = n_r;
    m_s        = m_r;
    res_base_s = res_base_r;
    col_s      = col_r;
    c_s        = c_r;
    row_s      = '0;
    start_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        col_s = '0;
        c_s   = '0;
        if (bus.cfg_we && cfg_ready_r) begin
          case (bus.cfg_addr)
            2'd0:    n_s        = bus.cfg_wdata[DIM_W-1:0];
            2'd1:    m_s        = bus.cfg_wdata[DIM_W-1:0];
            2'd2:    start_s    = bus.cfg_wdata[0];
            2'd3:    res_base_s = bus.cfg_wdata[ADDR_SIZE-1:0];
            default: start_s    = 1'b0;
          endcase
        end else begin
          start_s = 1'b0;
        end
        // An empty problem skips all memory activity and reports done at once.
        if (start_s) begin
          state_s = ((n_r != '0) && (m_r != '0)) ? S_FETCH : S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        row_s = row_r + ADDR_SIZE'(n_r);
        if (c_r == fetch_len_s - ONE_CW) begin
          state_s = S_DRAIN;
          c_s     = '0;
        end else begin
          c_s = c_r + ONE_CW;
        end
      end
      S_DRAIN: begin
        if (c_r == drain_len_s - ONE_CW) begin
          c_s = '0;
          if (col_r + PE_STEP < CW'(n_r)) begin
            state_s = S_FETCH;
            col_s   = col_r + PE_STEP;
          end else begin
            state_s = S_WRITE;
          end
        end else begin
          c_s = c_r + ONE_CW;
        end
      end
      S_WRITE: begin
        if (c_r == m_w_s - ONE_CW) begin
          state_s = S_DONE;
          c_s     = '0;
        end else begin
          c_s = c_r + ONE_CW;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
`ifdef MVM_SEQ_AUTOINC_EN
        if ((n_r != '0) && (m_r != '0)) begin
          res_base_s = res_base_r + ADDR_SIZE'(m_r);
        end else begin
          res_base_s = res_base_r;
        end
`endif
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Output values decoded from the current state; they reach the ports one edge later.
  always_comb begin
    busy_s    = (state_r == S_FETCH) || (state_r == S_DRAIN) || (state_r == S_WRITE);
    done_s    = (state_r == S_DONE);
    clr_s     = !busy_s;
    read_s    = (state_r == S_WRITE);
    w_addr_s  = read_s ? (res_base_r + ADDR_SIZE'(c_r)) : '0;
    pe_base_s = VEC_BASE + ADDR_SIZE'(n_r) + row_r + ADDR_SIZE'(col_r);
    l_d_s     = ZERO_POINT_ADDR;
    pe_s      = {PE_NUMBER{ZERO_POINT_ADDR}};
    if (state_r == S_FETCH) begin
      if (c_r < nt_s) begin
        l_d_s = VEC_BASE + ADDR_SIZE'(col_r) + ADDR_SIZE'(c_r);
      end else begin
        l_d_s = ZERO_POINT_ADDR;
      end
      for (int i = 0; i < PE_NUMBER; i++) begin
        if ((c_r < m_w_s) && (i < int'(nt_s))) begin
          pe_s[i] = pe_base_s + ADDR_SIZE'(i);
        end else begin
          pe_s[i] = ZERO_POINT_ADDR;
        end
      end
    end else begin
      l_d_s = ZERO_POINT_ADDR;
    end
  end

  // State, configuration and loop-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      n_r        <= '0;
      m_r        <= '0;
      res_base_r <= '0;
      col_r      <= '0;
      c_r        <= '0;
      row_r      <= '0;
    end else begin
      state_r    <= state_s;
      n_r        <= n_s;
      m_r        <= m_s;
      res_base_r <= res_base_s;
      col_r      <= col_s;
      c_r        <= c_s;
      row_r      <= row_s;
    end
  end

  // Output registers; cfg_ready follows the next state so it never admits a write outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      clr_r       <= 1'b1;
      read_r      <= 1'b0;
      w_en_r      <= 1'b0;
      w_addr_r    <= '0;
      l_d_r       <= ZERO_POINT_ADDR;
      pe_r        <= {PE_NUMBER{ZERO_POINT_ADDR}};
    end else begin
      cfg_ready_r <= (state_s == S_IDLE);
      busy_r      <= busy_s;
      done_r      <= done_s;
      clr_r       <= clr_s;
      read_r      <= read_s;
      w_en_r      <= read_s;
      w_addr_r    <= w_addr_s;
      l_d_r       <= l_d_s;
      pe_r        <= pe_s;
    end
  end

  assign bus.cfg_ready   = cfg_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.array_clr   = clr_r;
  assign bus.array_read  = read_r;
  assign bus.w_en        = w_en_r;
  assign bus.w_addr      = w_addr_r;
  assign bus.l_d_o_addr  = l_d_r;
  assign bus.pe_t_o_addr = pe_r;
endmodule
